// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC priority resolver and INTA sequencer.
package pic_pkg;

  localparam int unsigned NUM_IRQ    = 8;
  localparam int unsigned LVL_W      = 3;
  localparam int unsigned VEC_BASE_W = 5;

  typedef enum logic [1:0] {IDLE, PEND, ACK1} state_e;

  // Rank 0 is the highest priority: the level just above `lowest` in scan order.
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] level,
                                                 input logic [LVL_W-1:0] lowest);
    return level - lowest - LVL_W'(1);
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Combinational resolver: highest-ranked in-service level and the best request ranked above it.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [LVL_W-1:0]   lowest,
  output logic               valid,
  output logic [LVL_W-1:0]   winner,
  output logic [LVL_W-1:0]   isr_top,
  output logic               isr_any
);

  logic [LVL_W:0] top_rank;
  logic [LVL_W:0] best_rank;

  always_comb begin
    isr_any  = 1'b0;
    isr_top  = '0;
    top_rank = (LVL_W+1)'(NUM_IRQ);
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (isr[i] && ({1'b0, prio_rank(LVL_W'(i), lowest)} < top_rank)) begin
        isr_any  = 1'b1;
        isr_top  = LVL_W'(i);
        top_rank = {1'b0, prio_rank(LVL_W'(i), lowest)};
      end
    end

    // Only requests strictly above the in-service top can win.
    valid     = 1'b0;
    winner    = '1;
    best_rank = top_rank;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req[i] && ({1'b0, prio_rank(LVL_W'(i), lowest)} < best_rank)) begin
        valid     = 1'b1;
        winner    = LVL_W'(i);
        best_rank = {1'b0, prio_rank(LVL_W'(i), lowest)};
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// INT/INTA sequencer for the 8-input PIC: owns ISR, priority pointer, EOI handling and vector output.
module interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irr,
  input  logic                  inta,
  input  logic                  eoi,
  input  logic                  seoi,
  input  logic [LVL_W-1:0]      seoi_level,
  input  logic                  rotate_en,
  input  logic                  aeoi,
  input  logic [VEC_BASE_W-1:0] vector_base,
  output logic                  int_out,
  output logic [NUM_IRQ-1:0]    isr,
  output logic [NUM_IRQ-1:0]    clear_irr,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  output logic                  ack_timeout
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(ACK_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [LVL_W-1:0]   lowest_q, lowest_d, lowest_eff;
  logic [LVL_W-1:0]   win_q, win_d;
  logic               spur_q, spur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               int_q, int_d;
  logic [NUM_IRQ-1:0] clr_q, clr_d;
  logic [7:0]         data_q, data_d;
  logic               dv_q, dv_d;
  logic               to_q, to_d;

  logic               valid;
  logic [LVL_W-1:0]   winner;
  logic [LVL_W-1:0]   isr_top;
  logic               isr_any;

  assign lowest_eff = rotate_en ? lowest_q : '1;

  priority_resolver u_resolver (
    .req     (irr),
    .isr     (isr_q),
    .lowest  (lowest_eff),
    .valid   (valid),
    .winner  (winner),
    .isr_top (isr_top),
    .isr_any (isr_any)
  );

  always_comb begin
    state_d  = state_q;
    isr_d    = isr_q;
    lowest_d = lowest_eff;
    win_d    = win_q;
    spur_d   = spur_q;
    cnt_d    = cnt_q;
    clr_d    = '0;
    data_d   = data_q;
    dv_d     = 1'b0;
    to_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid) state_d = PEND;
      end
      PEND: begin
        if (inta) begin
          state_d = ACK1;
          cnt_d   = '0;
          spur_d  = !valid;
          win_d   = valid ? winner : '1;
          if (valid) begin
            isr_d[winner] = 1'b1;
            clr_d[winner] = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta) begin
          state_d = IDLE;
          data_d  = {vector_base, win_q};
          dv_d    = 1'b1;
          if (aeoi && !spur_q) begin
            isr_d[win_q] = 1'b0;
            if (rotate_en) lowest_d = win_q;
          end
        end else if (cnt_q == CntLast) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // EOI decisions use the pre-update ISR; the clear lands after any handshake set.
    if (seoi) begin
      isr_d[seoi_level] = 1'b0;
      if (rotate_en) lowest_d = seoi_level;
    end else if (eoi && isr_any) begin
      isr_d[isr_top] = 1'b0;
      if (rotate_en) lowest_d = isr_top;
    end

    int_d = (state_d == PEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      isr_q    <= '0;
      lowest_q <= '1;
      win_q    <= '1;
      spur_q   <= 1'b0;
      cnt_q    <= '0;
      int_q    <= 1'b0;
      clr_q    <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      isr_q    <= isr_d;
      lowest_q <= lowest_d;
      win_q    <= win_d;
      spur_q   <= spur_d;
      cnt_q    <= cnt_d;
      int_q    <= int_d;
      clr_q    <= clr_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      to_q     <= to_d;
    end
  end

  assign int_out     = int_q;
  assign isr         = isr_q;
  assign clear_irr   = clr_q;
  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign ack_timeout = to_q;

endmodule
